// File: rtl/acc_cpu_core_param_if.sv
// Command/response bundle of the accumulator core: the wrapper is the master
// that issues commands, the core is the slave that reports acc/flags/done.
`timescale 1ns/1ps
interface acc_cpu_core_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_opcode;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              wr_en;
  logic [DATA_W-1:0] acc_out;
  logic              flag_z;
  logic              flag_c;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_opcode, cmd_addr, cmd_data, wr_en,
    input  cmd_ready, acc_out, flag_z, flag_c, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_addr, cmd_data, wr_en,
    output cmd_ready, acc_out, flag_z, flag_c, busy, done, err
  );
endinterface

// File: rtl/acc_cpu_core_param.sv
// Parametrised accumulator core: valid/ready command intake, registered
// operand fetch from a small scratch memory, ALU with zero/carry flags.
`timescale 1ns/1ps
module acc_cpu_core_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input logic clk,
  input logic rst,
  acc_cpu_core_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_ADDM  = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_NOT   = 4'h8;
  localparam logic [3:0] OP_SHL   = 4'h9;
  localparam logic [3:0] OP_SHR   = 4'hA;
  localparam logic [3:0] OP_LDI   = 4'hB;
  localparam logic [3:0] OP_CLR   = 4'hC;

  typedef enum logic [1:0] {IDLE, READ, EXEC, DONE} state_t;

  state_t            state, state_next;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              wr_q;
  logic [DATA_W-1:0] operand_q;
  logic [DATA_W-1:0] acc;
  logic              z_q, c_q, done_q, err_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W:0]   sum_ext;
  logic              alu_c, acc_we, mem_we, alu_err;

  assign accept        = (state == IDLE) && bus.cmd_valid;
  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.acc_out   = acc;
  assign bus.flag_z    = z_q;
  assign bus.flag_c    = c_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.cmd_valid)
              state_next = (bus.cmd_opcode == OP_LOAD || bus.cmd_opcode == OP_ADDM) ? READ : EXEC;
      READ: state_next = EXEC;
      EXEC: state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The ALU only looks at latched command fields, so the wrapper may change
  // the command inputs as soon as the accept edge has passed.
  always_comb begin
    alu_res = acc;
    alu_c   = 1'b0;
    sum_ext = '0;
    acc_we  = 1'b1;
    mem_we  = 1'b0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD: begin
        sum_ext = {1'b0, acc} + {1'b0, data_q};
        alu_res = sum_ext[DATA_W-1:0];
        alu_c   = sum_ext[DATA_W];
      end
      OP_SUB: begin
        sum_ext = {1'b0, acc} - {1'b0, data_q};
        alu_res = sum_ext[DATA_W-1:0];
        alu_c   = sum_ext[DATA_W];
      end
      OP_STORE: begin
        acc_we  = 1'b0;
        mem_we  = wr_q;
        alu_err = ~wr_q;
      end
      OP_LOAD: alu_res = operand_q;
      OP_ADDM: begin
        sum_ext = {1'b0, acc} + {1'b0, operand_q};
        alu_res = sum_ext[DATA_W-1:0];
        alu_c   = sum_ext[DATA_W];
      end
      OP_AND: alu_res = acc & data_q;
      OP_OR:  alu_res = acc | data_q;
      OP_XOR: alu_res = acc ^ data_q;
      OP_NOT: alu_res = ~acc;
      OP_SHL: begin
        alu_res = {acc[DATA_W-2:0], 1'b0};
        alu_c   = acc[DATA_W-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, acc[DATA_W-1:1]};
        alu_c   = acc[0];
      end
      OP_LDI: alu_res = data_q;
      OP_CLR: alu_res = '0;
      default: begin
        acc_we  = 1'b0;
        alu_err = 1'b1;
      end
    endcase
  end

  // Reset wipes the whole scratch memory and drops any in-flight command.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      op_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      operand_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept) begin
        op_q   <= bus.cmd_opcode;
        addr_q <= bus.cmd_addr;
        data_q <= bus.cmd_data;
        wr_q   <= bus.wr_en;
      end
      if (state == READ) operand_q <= mem[addr_q];
      if (state == EXEC) begin
        done_q <= 1'b1;
        err_q  <= alu_err;
        if (acc_we) begin
          acc <= alu_res;
          c_q <= alu_c;
          z_q <= (alu_res == '0);
        end
        if (mem_we) mem[addr_q] <= acc;
      end
    end
  end
endmodule
